// File: rtl/regfile_32x32_pkg.sv
// Shared constants for the 32x32 register file.
//   REG_WIDTH  : data width of one register
//   REG_COUNT  : number of architectural registers
//   REG_ADDR_W : register address width
//   ZERO_REG   : index of the hardwired-zero register
package regfile_32x32_pkg;

  localparam int unsigned REG_WIDTH  = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : regfile_32x32_pkg

// File: rtl/register32.sv
// Single register entry with load enable and asynchronous active-low clear.
//   clk         : rising-edge clock
//   reset       : asynchronous active-low clear
//   writeEnable : load inData at the next rising edge
//   inData      : value to load
//   outData     : stored value
module register32
  import regfile_32x32_pkg::*;
#(
  parameter int unsigned WIDTH = REG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] inData,
  output logic [WIDTH-1:0] outData
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outData <= '0;
    end else if (writeEnable) begin
      outData <= inData;
    end
  end

endmodule : register32

// File: rtl/regfile_32x32.sv
// 32-entry register file: two combinational read ports, one synchronous write
// port, hardwired zero register and a per-register pending (busy) scoreboard.
//   clk, reset            : rising-edge clock, asynchronous active-low clear
//   rsAddr/rsData/rsBusy  : read port A address, data, pending flag
//   rtAddr/rtData/rtBusy  : read port B address, data, pending flag
//   rdAddr/inData         : write address and data
//   writeEnable           : commit inData to rdAddr; also retires busy[rdAddr]
//   busySet/busyAddr      : claim busyAddr for a multi-cycle producer
module regfile_32x32
  import regfile_32x32_pkg::*;
#(
  parameter int unsigned WIDTH  = REG_WIDTH,
  parameter int unsigned DEPTH  = REG_COUNT,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rsAddr,
  input  logic [REG_ADDR_W-1:0] rtAddr,
  output logic [WIDTH-1:0]      rsData,
  output logic [WIDTH-1:0]      rtData,
  input  logic [REG_ADDR_W-1:0] rdAddr,
  input  logic [WIDTH-1:0]      inData,
  input  logic                  writeEnable,
  input  logic                  busySet,
  input  logic [REG_ADDR_W-1:0] busyAddr,
  output logic                  rsBusy,
  output logic                  rtBusy
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             rs_match;
  logic             rt_match;
  logic             rs_fwd;
  logic             rt_fwd;

  // Entry 0 is a constant; writes to it have no storage to land in.
  assign regs[0] = '0;

  for (genvar i = 1; i < int'(DEPTH); i++) begin : g_entry
    register32 #(
      .WIDTH(WIDTH)
    ) u_reg (
      .clk         (clk),
      .reset       (reset),
      .writeEnable (writeEnable && (rdAddr == REG_ADDR_W'(i))),
      .inData      (inData),
      .outData     (regs[i])
    );
  end

  // Clear on retire first, then set, so a new claim wins over a same-cycle retire.
  always_comb begin
    busy_nxt = busy;
    if (writeEnable && (rdAddr != ZERO_REG)) begin
      busy_nxt[rdAddr] = 1'b0;
    end
    if (busySet && (busyAddr != ZERO_REG)) begin
      busy_nxt[busyAddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign rs_match = writeEnable && (rdAddr == rsAddr);
  assign rt_match = writeEnable && (rdAddr == rtAddr);

  // Forwarding is suppressed while reset is held so the ports read zero.
  assign rs_fwd = BYPASS && reset && rs_match && (rdAddr != ZERO_REG);
  assign rt_fwd = BYPASS && reset && rt_match && (rdAddr != ZERO_REG);

  assign rsData = rs_fwd ? inData : regs[rsAddr];
  assign rtData = rt_fwd ? inData : regs[rtAddr];

  assign rsBusy = busy[rsAddr] & ~(BYPASS & rs_match);
  assign rtBusy = busy[rtAddr] & ~(BYPASS & rt_match);

endmodule : regfile_32x32
